// File: rtl/neuron_operand_loader.sv
// neuron_operand_loader: assembles a serial valid/ready word stream into frozen A/B operand buses
// and frames each operand set with a START strobe, a BUSY hold window and a DONE pulse.
module neuron_operand_loader #(
  parameter int DWIDTH = 32,
  parameter int IDIM = 1,
  parameter int ODIM = 2,
  parameter int HOLD = 4,
  parameter int ASIZE = DWIDTH*IDIM,
  parameter int BSIZE = DWIDTH*ODIM
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              CLEAR,
  input  logic [DWIDTH-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [ASIZE-1:0]  STREAM_A,
  output logic [BSIZE-1:0]  STREAM_B,
  output logic              START,
  output logic              BUSY,
  output logic              DONE
);
  localparam int MD = IDIM > ODIM ? IDIM : ODIM;
  localparam int IW = $clog2(MD) > 1 ? $clog2(MD) : 1;
  localparam int CW = $clog2(HOLD) > 1 ? $clog2(HOLD) : 1;
  localparam logic [IW-1:0] a_last = IW'(IDIM - 1);
  localparam logic [IW-1:0] b_last = IW'(ODIM - 1);
  localparam logic [CW-1:0] c_load = CW'(HOLD - 1);
  typedef enum logic [2:0] {s_idle, s_load_a, s_load_b, s_fire, s_hold} state_t;
  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          take;
  // Handshake outputs decode only registered state, so IN_VALID never reaches IN_READY.
  assign IN_READY = state == s_load_a || state == s_load_b;
  assign START    = state == s_fire;
  assign BUSY     = state == s_fire || state == s_hold;
  assign take     = IN_VALID && IN_READY;
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      state    <= s_idle;
      idx      <= '0;
      cnt      <= '0;
      STREAM_A <= '0;
      STREAM_B <= '0;
      DONE     <= 1'b0;
    end else if (CLEAR) begin
      state    <= s_load_a;
      idx      <= '0;
      cnt      <= '0;
      STREAM_A <= '0;
      STREAM_B <= '0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        s_idle: state <= s_load_a;
        s_load_a:
          if (take) begin
            for (int i = 0; i < IDIM; i++)
              if (idx == IW'(i)) STREAM_A[i*DWIDTH +: DWIDTH] <= IN_DATA;
            idx <= idx == a_last ? '0 : idx + 1'b1;
            if (idx == a_last) state <= s_load_b;
          end
        s_load_b:
          if (take) begin
            for (int i = 0; i < ODIM; i++)
              if (idx == IW'(i)) STREAM_B[i*DWIDTH +: DWIDTH] <= IN_DATA;
            idx <= idx == b_last ? '0 : idx + 1'b1;
            if (idx == b_last) state <= s_fire;
          end
        s_fire: begin
          cnt   <= c_load;
          state <= s_hold;
        end
        s_hold:
          if (cnt == '0) begin
            state <= s_load_a;
            DONE  <= 1'b1;
          end else cnt <= cnt - 1'b1;
        default: state <= s_idle;
      endcase
    end
endmodule

// File: tb/tb_neuron_operand_loader.sv
// tb_neuron_operand_loader: directed and random stimulus checked cycle by cycle against a
// word-count / busy-window reference model of the loader.
module tb_neuron_operand_loader;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, valid = 1'b0;
  logic [31:0] data = '0;
  logic rdy0, st0, bz0, dn0, rdy1, st1, bz1, dn1;
  logic [31:0] a0;
  logic [63:0] b0, a1;
  logic [95:0] b1;
  int compared = 0, mismatched = 0;
  int starts, cyc_n, last_start, gap;
  bit sel, m_idle, m_done, acc;
  int mi, mo, mh, m_k, m_busy;
  logic [31:0] ma [8];
  logic [31:0] mb [8];
  logic [31:0] wq [$];

  always #5 clk = ~clk;

  neuron_operand_loader u0 (
    .CLOCK(clk), .RESET_N(rst_n), .CLEAR(clear), .IN_DATA(data), .IN_VALID(valid),
    .IN_READY(rdy0), .STREAM_A(a0), .STREAM_B(b0), .START(st0), .BUSY(bz0), .DONE(dn0));

  neuron_operand_loader #(.DWIDTH(32), .IDIM(2), .ODIM(3), .HOLD(1)) u1 (
    .CLOCK(clk), .RESET_N(rst_n), .CLEAR(clear), .IN_DATA(data), .IN_VALID(valid),
    .IN_READY(rdy1), .STREAM_A(a1), .STREAM_B(b1), .START(st1), .BUSY(bz1), .DONE(dn1));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_done = 1'b0;
    m_k = 0;
    m_busy = 0;
    for (int i = 0; i < 8; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
  endtask

  // Loader as seen from outside: words fill A then B; a full set opens a HOLD+1 busy window.
  task automatic model_update();
    acc = 1'b0;
    if (clear) begin
      model_reset();
      m_idle = 1'b0;
    end else begin
      m_done = m_busy == 1;
      if (m_idle) m_idle = 1'b0;
      else if (m_busy > 0) m_busy--;
      else if (valid) begin
        acc = 1'b1;
        if (m_k < mi) ma[m_k] = data;
        else mb[m_k - mi] = data;
        m_k++;
        if (m_k == mi + mo) begin
          m_k = 0;
          m_busy = mh + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [255:0] ea, eb;
    ea = '0;
    eb = '0;
    for (int i = 0; i < mi; i++) ea[i*32 +: 32] = ma[i];
    for (int i = 0; i < mo; i++) eb[i*32 +: 32] = mb[i];
    chk("in_ready", 256'(sel ? rdy1 : rdy0), 256'(!m_idle && m_busy == 0));
    chk("start", 256'(sel ? st1 : st0), 256'(m_busy == mh + 1));
    chk("busy", 256'(sel ? bz1 : bz0), 256'(m_busy != 0));
    chk("done", 256'(sel ? dn1 : dn0), 256'(m_done));
    chk("stream_a", sel ? 256'(a1) : 256'(a0), ea);
    chk("stream_b", sel ? 256'(b1) : 256'(b0), eb);
  endtask

  task automatic cyc(input bit v, input logic [31:0] d);
    valid = v;
    data = d;
    model_update();
    @(negedge clk);
    cyc_n++;
    if (sel ? st1 : st0) begin
      starts++;
      gap = cyc_n - last_start;
      last_start = cyc_n;
    end
    check_all();
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++)
      if (wq.size() > 0) begin
        cyc(1'b1, wq[0]);
        if (acc) void'(wq.pop_front());
      end else cyc(1'b0, 32'h0);
  endtask

  task automatic do_reset(input bit v);
    rst_n = 1'b0;
    valid = v;
    data = 32'h11;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    sel = 1'b0; mi = 1; mo = 2; mh = 4;
    cyc_n = 0; last_start = 0; gap = 0;
    // basic load with IN_VALID already high at reset release
    do_reset(1'b1);
    wq = '{32'h11, 32'h22, 32'h33};
    starts = 0;
    feed(12);
    chk("s1_start_count", 256'(starts), 256'(1));
    chk("s1_a", 256'(a0), 256'(32'h11));
    chk("s1_b", 256'(b0), 256'({32'h33, 32'h22}));
    // back-to-back operand sets
    wq = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    starts = 0;
    feed(20);
    chk("s2_start_count", 256'(starts), 256'(2));
    chk("s2_start_gap", 256'(gap), 256'(8));
    // stalls
    starts = 0;
    cyc(1'b1, 32'hA);
    cyc(1'b0, 32'hEE);
    cyc(1'b0, 32'hEF);
    cyc(1'b1, 32'hB);
    cyc(1'b0, 32'hF0);
    cyc(1'b1, 32'hC);
    feed(8);
    chk("s3_start_count", 256'(starts), 256'(1));
    chk("s3_a", 256'(a0), 256'(32'hA));
    chk("s3_b", 256'(b0), 256'({32'hC, 32'hB}));
    // CLEAR in the second BUSY cycle
    wq = '{32'h71, 32'h72, 32'h73};
    feed(3);
    cyc(1'b0, 32'h0);
    clear = 1'b1;
    cyc(1'b1, 32'h99);
    clear = 1'b0;
    chk("s4_busy_after_clear", 256'(bz0), 256'(0));
    chk("s4_a_cleared", 256'(a0), 256'(0));
    cyc(1'b1, 32'h5A);
    chk("s4_next_word_in_a", 256'(a0), 256'(32'h5A));
    // asynchronous reset in the middle of LOAD_B
    clear = 1'b1;
    cyc(1'b0, 32'h0);
    clear = 1'b0;
    wq = '{32'h55, 32'h66};
    feed(2);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("s5_async_b", 256'(b0), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wq = '{32'h11, 32'h22, 32'h33};
    starts = 0;
    feed(12);
    chk("s5_start_count", 256'(starts), 256'(1));
    chk("s5_b", 256'(b0), 256'({32'h33, 32'h22}));
    // second geometry: IDIM=2, ODIM=3, HOLD=1
    sel = 1'b1; mi = 2; mo = 3; mh = 1;
    do_reset(1'b0);
    wq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    starts = 0;
    feed(12);
    chk("s6_a", 256'(a1), 256'({32'd2, 32'd1}));
    chk("s6_b", 256'(b1), 256'({32'd5, 32'd4, 32'd3}));
    chk("s6_start_count", 256'(starts), 256'(1));
    // random traffic on both geometries
    for (int s = 0; s < 2; s++) begin
      if (s == 1) begin
        sel = 1'b0; mi = 1; mo = 2; mh = 4;
        do_reset(1'b0);
      end
      for (int i = 0; i < 400; i++) begin
        clear = $urandom_range(0, 40) == 0;
        cyc($urandom_range(0, 3) != 0, $urandom);
        clear = 1'b0;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
